// File: rtl/chip8_pkg.sv
// Shared constants and state type for the CHIP-8 main memory block.
package chip8_pkg;

  localparam logic [11:0] FONT_BASE    = 12'h050;
  localparam logic [11:0] PROGRAM_BASE = 12'h200;
  localparam int          FONT_BYTES   = 80;
  localparam int          MEM_DEPTH    = 4096;

  typedef enum logic [1:0] {
    INIT_FONT = 2'd0,
    LOAD      = 2'd1,
    RUN       = 2'd2
  } mem_state_e;

  function automatic logic font_index_last(input logic [6:0] idx);
    return idx == 7'(FONT_BYTES - 1);
  endfunction

endpackage

// File: rtl/chip8_font_rom.sv
// Combinational glyph table: 16 hex digits x 5 rows, index = digit*5 + row.
module chip8_font_rom (
  input  logic [6:0] index,
  output logic [7:0] glyph
);

  always_comb begin
    glyph = 8'h00;
    case (index)
      7'd0:  glyph = 8'hF0; 7'd1:  glyph = 8'h90; 7'd2:  glyph = 8'h90; 7'd3:  glyph = 8'h90; 7'd4:  glyph = 8'hF0;
      7'd5:  glyph = 8'h20; 7'd6:  glyph = 8'h60; 7'd7:  glyph = 8'h20; 7'd8:  glyph = 8'h20; 7'd9:  glyph = 8'h70;
      7'd10: glyph = 8'hF0; 7'd11: glyph = 8'h10; 7'd12: glyph = 8'hF0; 7'd13: glyph = 8'h80; 7'd14: glyph = 8'hF0;
      7'd15: glyph = 8'hF0; 7'd16: glyph = 8'h10; 7'd17: glyph = 8'hF0; 7'd18: glyph = 8'h10; 7'd19: glyph = 8'hF0;
      7'd20: glyph = 8'h90; 7'd21: glyph = 8'h90; 7'd22: glyph = 8'hF0; 7'd23: glyph = 8'h10; 7'd24: glyph = 8'h10;
      7'd25: glyph = 8'hF0; 7'd26: glyph = 8'h80; 7'd27: glyph = 8'hF0; 7'd28: glyph = 8'h10; 7'd29: glyph = 8'hF0;
      7'd30: glyph = 8'hF0; 7'd31: glyph = 8'h80; 7'd32: glyph = 8'hF0; 7'd33: glyph = 8'h90; 7'd34: glyph = 8'hF0;
      7'd35: glyph = 8'hF0; 7'd36: glyph = 8'h10; 7'd37: glyph = 8'h20; 7'd38: glyph = 8'h40; 7'd39: glyph = 8'h40;
      7'd40: glyph = 8'hF0; 7'd41: glyph = 8'h90; 7'd42: glyph = 8'hF0; 7'd43: glyph = 8'h90; 7'd44: glyph = 8'hF0;
      7'd45: glyph = 8'hF0; 7'd46: glyph = 8'h90; 7'd47: glyph = 8'hF0; 7'd48: glyph = 8'h10; 7'd49: glyph = 8'hF0;
      7'd50: glyph = 8'hF0; 7'd51: glyph = 8'h90; 7'd52: glyph = 8'hF0; 7'd53: glyph = 8'h90; 7'd54: glyph = 8'h90;
      7'd55: glyph = 8'hE0; 7'd56: glyph = 8'h90; 7'd57: glyph = 8'hE0; 7'd58: glyph = 8'h90; 7'd59: glyph = 8'hE0;
      7'd60: glyph = 8'hF0; 7'd61: glyph = 8'h80; 7'd62: glyph = 8'h80; 7'd63: glyph = 8'h80; 7'd64: glyph = 8'hF0;
      7'd65: glyph = 8'hE0; 7'd66: glyph = 8'h90; 7'd67: glyph = 8'h90; 7'd68: glyph = 8'h90; 7'd69: glyph = 8'hE0;
      7'd70: glyph = 8'hF0; 7'd71: glyph = 8'h80; 7'd72: glyph = 8'hF0; 7'd73: glyph = 8'h80; 7'd74: glyph = 8'hF0;
      7'd75: glyph = 8'hF0; 7'd76: glyph = 8'h80; 7'd77: glyph = 8'hF0; 7'd78: glyph = 8'h80; 7'd79: glyph = 8'h80;
      default: glyph = 8'h00;
    endcase
  end

endmodule

// File: rtl/chip8_memory.sv
// 4096x8 CHIP-8 main memory: font init, then program load stream, then CPU access.
module chip8_memory #(
  parameter logic [11:0] FONT_BASE    = chip8_pkg::FONT_BASE,
  parameter logic [11:0] PROGRAM_BASE = chip8_pkg::PROGRAM_BASE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] address,
  output logic [7:0]  data_out,
  input  logic        write_enable,
  input  logic [7:0]  write_data,
  input  logic        load_valid,
  input  logic [7:0]  load_data,
  input  logic        load_last,
  output logic        load_ready,
  output logic        busy
);

  import chip8_pkg::*;

  logic [7:0]  mem [MEM_DEPTH];

  mem_state_e  state_q, state_d;
  logic [6:0]  font_idx_q, font_idx_d;
  logic [11:0] ptr_q, ptr_d;
  logic [7:0]  data_out_q, data_out_d;

  logic [7:0]  font_glyph;
  logic        wr_en;
  logic [11:0] wr_addr;
  logic [7:0]  wr_data;
  logic        load_accept;

  chip8_font_rom u_font_rom (
    .index (font_idx_q),
    .glyph (font_glyph)
  );

  assign load_ready  = (state_q == LOAD);
  assign busy        = (state_q != RUN);
  assign load_accept = load_ready && load_valid;
  assign data_out    = data_out_q;

  always_comb begin
    state_d    = state_q;
    font_idx_d = font_idx_q;
    ptr_d      = ptr_q;
    case (state_q)
      INIT_FONT: begin
        font_idx_d = font_idx_q + 7'd1;
        if (font_index_last(font_idx_q)) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (load_accept) begin
          ptr_d = ptr_q + 12'd1;
          // Top of memory ends the load so the pointer never wraps into font space.
          if (load_last || (ptr_q == 12'hFFF)) begin
            state_d = RUN;
          end
        end
      end
      RUN:     state_d = RUN;
      default: state_d = INIT_FONT;
    endcase
  end

  // Single write port shared by font init, loader and CPU; only one owner per state.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = 12'h000;
    wr_data = 8'h00;
    case (state_q)
      INIT_FONT: begin
        wr_en   = 1'b1;
        wr_addr = FONT_BASE + {5'd0, font_idx_q};
        wr_data = font_glyph;
      end
      LOAD: begin
        wr_en   = load_accept;
        wr_addr = ptr_q;
        wr_data = load_data;
      end
      RUN: begin
        wr_en   = write_enable;
        wr_addr = address;
        wr_data = write_data;
      end
      default: wr_en = 1'b0;
    endcase
  end

  // Read sees the array before this edge's write lands, giving read-first behaviour.
  always_comb begin
    data_out_d = mem[address];
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= INIT_FONT;
      font_idx_q <= 7'd0;
      ptr_q      <= PROGRAM_BASE;
      data_out_q <= 8'h00;
    end else begin
      state_q    <= state_d;
      font_idx_q <= font_idx_d;
      ptr_q      <= ptr_d;
      data_out_q <= data_out_d;
    end
  end

endmodule

// File: tb/tb_chip8_memory.sv
// Randomised bench for chip8_memory against a byte-array reference model.
module tb_chip8_memory;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] address = 12'h000;
  logic [7:0]  data_out;
  logic        write_enable = 1'b0;
  logic [7:0]  write_data = 8'h00;
  logic        load_valid = 1'b0;
  logic [7:0]  load_data = 8'h00;
  logic        load_last = 1'b0;
  logic        load_ready;
  logic        busy;

  chip8_memory dut (
    .clk          (clk),
    .reset        (reset),
    .address      (address),
    .data_out     (data_out),
    .write_enable (write_enable),
    .write_data   (write_data),
    .load_valid   (load_valid),
    .load_data    (load_data),
    .load_last    (load_last),
    .load_ready   (load_ready),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  logic [7:0] font_tbl [80] = '{
    8'hF0, 8'h90, 8'h90, 8'h90, 8'hF0,  8'h20, 8'h60, 8'h20, 8'h20, 8'h70,
    8'hF0, 8'h10, 8'hF0, 8'h80, 8'hF0,  8'hF0, 8'h10, 8'hF0, 8'h10, 8'hF0,
    8'h90, 8'h90, 8'hF0, 8'h10, 8'h10,  8'hF0, 8'h80, 8'hF0, 8'h10, 8'hF0,
    8'hF0, 8'h80, 8'hF0, 8'h90, 8'hF0,  8'hF0, 8'h10, 8'h20, 8'h40, 8'h40,
    8'hF0, 8'h90, 8'hF0, 8'h90, 8'hF0,  8'hF0, 8'h90, 8'hF0, 8'h10, 8'hF0,
    8'hF0, 8'h90, 8'hF0, 8'h90, 8'h90,  8'hE0, 8'h90, 8'hE0, 8'h90, 8'hE0,
    8'hF0, 8'h80, 8'h80, 8'h80, 8'hF0,  8'hE0, 8'h90, 8'h90, 8'h90, 8'hE0,
    8'hF0, 8'h80, 8'hF0, 8'h80, 8'hF0,  8'hF0, 8'h80, 8'hF0, 8'h80, 8'h80
  };

  // Reference model: contents, which bytes are defined, and load progress.
  logic [7:0] model_mem   [4096];
  bit         model_known [4096];
  int         model_ptr;
  bit         model_load;
  bit         model_run;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic model_reset();
    model_ptr  = 12'h200;
    model_load = 1'b0;
    model_run  = 1'b0;
    for (int a = 0; a < 4096; a++) model_known[a] = 1'b0;
  endtask

  // Releases reset (or starts after a reset), holds the loader busy and measures init length.
  task automatic wait_init(input string tag);
    int  cyc;
    bit  seen;
    cyc  = 0;
    seen = 1'b0;
    reset = 1'b0;
    for (int k = 0; k < 200; k++) begin
      load_valid = 1'b1;
      load_data  = 8'($urandom);
      load_last  = 1'($urandom);
      @(negedge clk);
      cyc++;
      if (load_ready) begin
        seen = 1'b1;
        break;
      end
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
    check({tag, "_init_cycles"}, seen ? cyc : 0, 80);
    check({tag, "_busy_in_load"}, busy, 1'b1);
    for (int k = 0; k < 80; k++) begin
      model_mem[12'h050 + k]   = font_tbl[k];
      model_known[12'h050 + k] = 1'b1;
    end
    model_load = 1'b1;
  endtask

  task automatic load_byte(input bit v, input logic [7:0] d, input bit l, input bit chk);
    bit acc;
    load_valid = v;
    load_data  = d;
    load_last  = l;
    acc = v && model_load && !model_run;
    @(negedge clk);
    if (acc) begin
      model_mem[model_ptr]   = d;
      model_known[model_ptr] = 1'b1;
      if (l || model_ptr == 12'hFFF) model_run = 1'b1;
      model_ptr++;
    end
    if (chk) begin
      check("busy", busy, !model_run);
      check("load_ready", load_ready, model_load && !model_run);
    end
  endtask

  task automatic read_chk(input logic [11:0] a, input string tag);
    address      = a;
    write_enable = 1'b0;
    load_valid   = 1'b0;
    @(negedge clk);
    if (model_known[a]) check(tag, data_out, model_mem[a]);
  endtask

  // One CPU cycle in RUN: read-first reference, then apply the store.
  task automatic run_step(input logic [11:0] a, input bit we, input logic [7:0] wd, input string tag);
    bit         k_before;
    logic [7:0] v_before;
    address      = a;
    write_enable = we;
    write_data   = wd;
    k_before = model_known[a];
    v_before = model_mem[a];
    @(negedge clk);
    if (k_before) check(tag, data_out, v_before);
    if (we && model_run) begin
      model_mem[a]   = wd;
      model_known[a] = 1'b1;
    end
  endtask

  function automatic logic [11:0] pick_addr();
    logic [11:0] bases [4];
    bases[0] = 12'h050; bases[1] = 12'h200; bases[2] = 12'h300; bases[3] = 12'hFF0;
    return bases[$urandom_range(0, 3)] + 12'($urandom_range(0, 7));
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] stream_d [5];
    bit         stream_v [5];
    bit         stream_l [5];
    int         budget;
    model_reset();

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_data_out", data_out, 8'h00);
    check("rst_busy", busy, 1'b1);
    check("rst_load_ready", load_ready, 1'b0);

    wait_init("first");

    // Program stream with a one-cycle gap; last flag on the fourth byte.
    stream_v = '{1, 0, 1, 1, 1};
    stream_d = '{8'h12, 8'hEE, 8'h34, 8'hA2, 8'h2A};
    stream_l = '{0, 1, 0, 0, 1};
    for (int k = 0; k < 5; k++) load_byte(stream_v[k], stream_d[k], stream_l[k], 1'b1);
    check("stream_busy_low", busy, 1'b0);

    for (int a = 12'h200; a < 12'h204; a++) read_chk(12'(a), "prog_rd");
    for (int k = 0; k < 80; k++) read_chk(12'h050 + 12'(k), "font_rd");
    read_chk(12'h09F, "font_last");

    // Read-during-write returns the old byte; the following read returns the new one.
    run_step(12'h300, 1'b1, 8'h11, "rdw_pre");
    run_step(12'h300, 1'b1, 8'h5A, "rdw_old");
    run_step(12'h300, 1'b0, 8'h00, "rdw_new");

    // Loader traffic in RUN must be refused.
    for (int k = 0; k < 5; k++) load_byte(1'b1, 8'hFF, 1'($urandom), 1'b1);
    read_chk(12'h200, "run_loader_ignored");

    for (int k = 0; k < 300; k++) begin
      run_step(pick_addr(), 1'($urandom), 8'($urandom), "run_rand");
      load_valid = 1'($urandom);
      if (k % 50 == 0) check("run_load_ready", load_ready, 1'b0);
    end

    // Second boot: CPU store attempts during init/load, then reset at load byte 2.
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    write_enable = 1'b1;
    address      = 12'h060;
    write_data   = 8'h00;
    wait_init("second");
    load_byte(1'b1, 8'h77, 1'b0, 1'b1);
    load_byte(1'b1, 8'h66, 1'b0, 1'b1);
    write_enable = 1'b0;
    read_chk(12'h050, "pre_reset_rd");
    #2;
    reset = 1'b1;
    #1;
    check("midload_busy", busy, 1'b1);
    check("midload_load_ready", load_ready, 1'b0);
    check("midload_data_out", data_out, 8'h00);
    @(negedge clk);
    model_reset();
    wait_init("third");

    // Full-length load with gaps and CPU stores held on; ends at 0xFFF.
    write_enable = 1'b1;
    address      = 12'h051;
    write_data   = 8'h00;
    budget = 0;
    while (!model_run && budget < 8000) begin
      load_byte(($urandom % 4) != 0, 8'($urandom), 1'b0, (budget % 16) == 0);
      budget++;
    end
    write_enable = 1'b0;
    check("bigload_busy", busy, 1'b0);
    check("bigload_load_ready", load_ready, 1'b0);
    load_byte(1'b1, 8'hC3, 1'b0, 1'b1);
    read_chk(12'h050, "bigload_font50");
    read_chk(12'h051, "bigload_font51");
    read_chk(12'h060, "bigload_font60");
    read_chk(12'h200, "bigload_ptr_restart");
    read_chk(12'hFFF, "bigload_top");
    for (int k = 0; k < 40; k++) read_chk(12'($urandom_range(12'h050, 12'hFFF)), "bigload_rand");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
